dadda_mul_sched: RTL and testbench

//   Shares one 32x32 dadda_multiplier instance among NUM_REQ requesters.

---
 rtl/dadda_mul_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_dadda_mul_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mul_sched.sv
// dadda_mul_sched: shares one 32x32 multiplier among NUM_REQ requesters
// with round-robin arbitration and valid/ready handshakes on both sides.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_a/req_b/
//   req_signed per requester; rsp_valid/rsp_ready/rsp_id/rsp_product; busy.
// Config: define DADDA_SCHED_SIGNED_EN to honour req_signed
//   (magnitude conversion plus sign fix-up); otherwise operands are unsigned.

module dadda_multiplier (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] p_o
);
    logic [63:0] s, c, pp, t;

    // Carry-save 3:2 reduction of the partial-product rows, one final add.
    always_comb begin
        s  = '0;
        c  = '0;
        pp = '0;
        t  = '0;
        for (int i = 0; i < 32; i++) begin
            pp = b_i[i] ? ({32'b0, a_i} << i) : 64'b0;
            t  = s ^ c ^ pp;
            c  = ((s & c) | (s & pp) | (c & pp)) << 1;
            s  = t;
        end
        p_o = s + c;
    end
endmodule

module dadda_mul_sched #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*32-1:0]      req_a,
    input  logic [NUM_REQ*32-1:0]      req_b,
    input  logic [NUM_REQ-1:0]         req_signed,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [63:0]                rsp_product,
    output logic                       busy
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    generate
        if (MUL_LAT < 1) begin : g_bad_lat
            $error("dadda_mul_sched: MUL_LAT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [63:0]      rsp_prod_q, rsp_prod_d;

    logic [IDW-1:0]   gnt;
    logic             gnt_vld;
    logic [31:0]      sel_a, sel_b;
    logic [31:0]      in_a, in_b;
    logic [63:0]      prod, prod_fix;

`ifdef DADDA_SCHED_SIGNED_EN
    logic             neg_q, neg_d;
    logic             sel_s, neg_in;
`else
    logic             unused_signed;
    assign unused_signed = ^req_signed;
`endif

    // Round-robin search starting just after the last winner.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [IDW-1:0] gi;
            gi = IDW'((int'(last_q) + 1 + k) % NUM_REQ);
            if (!gnt_vld && req_valid[gi]) begin
                gnt_vld = 1'b1;
                gnt     = gi;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
`ifdef DADDA_SCHED_SIGNED_EN
        sel_s = 1'b0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt == IDW'(k)) begin
                sel_a = req_a[32*k +: 32];
                sel_b = req_b[32*k +: 32];
`ifdef DADDA_SCHED_SIGNED_EN
                sel_s = req_signed[k];
`endif
            end
        end
    end

`ifdef DADDA_SCHED_SIGNED_EN
    // -(2^31) as 32-bit unsigned is 2^31, so the magnitude always fits.
    assign in_a     = (sel_s && sel_a[31]) ? (~sel_a + 32'd1) : sel_a;
    assign in_b     = (sel_s && sel_b[31]) ? (~sel_b + 32'd1) : sel_b;
    assign neg_in   = sel_s & (sel_a[31] ^ sel_b[31]);
    assign prod_fix = neg_q ? (~prod + 64'd1) : prod;
`else
    assign in_a     = sel_a;
    assign in_b     = sel_b;
    assign prod_fix = prod;
`endif

    dadda_multiplier u_mul (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .p_o (prod)
    );

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && !rst && gnt_vld) begin
            req_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_prod_d  = rsp_prod_q;
`ifdef DADDA_SCHED_SIGNED_EN
        neg_d       = neg_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    op_a_d  = in_a;
                    op_b_d  = in_b;
`ifdef DADDA_SCHED_SIGNED_EN
                    neg_d   = neg_in;
`endif
                    id_d    = gnt;
                    last_d  = gnt;
                    cnt_d   = CW'(MUL_LAT - 1);
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    rsp_prod_d  = prod_fix;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= IDW'(NUM_REQ - 1);
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
`ifdef DADDA_SCHED_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_prod_q  <= rsp_prod_d;
`ifdef DADDA_SCHED_SIGNED_EN
            neg_q       <= neg_d;
`endif
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_prod_q;
    assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_dadda_mul_sched.sv
// tb_dadda_mul_sched: directed steps with a response scoreboard
// for dadda_mul_sched (NUM_REQ=4, MUL_LAT=2).

module tb_dadda_mul_sched;
    localparam int NR  = 4;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*32-1:0] req_a, req_b;
    logic [NR-1:0]   req_signed;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [63:0]     rsp_product;
    logic            busy;

    logic [31:0] a_arr [NR];
    logic [31:0] b_arr [NR];

    typedef struct {
        logic [1:0]  id;
        logic [63:0] prod;
    } exp_t;

    exp_t        sb[$];
    int          grant_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] last_prod = '0;
    logic [NR-1:0] prev_rdy = '0;

    dadda_mul_sched #(.NUM_REQ(NR), .MUL_LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_signed  (req_signed),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_a[32*i +: 32] = a_arr[i];
            req_b[32*i +: 32] = b_arr[i];
        end
    end

    function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic s);
        logic signed [63:0] sa, sb2;
`ifdef DADDA_SCHED_SIGNED_EN
        if (s) begin
            sa  = {{32{a[31]}}, a};
            sb2 = {{32{b[31]}}, b};
            return 64'(sa * sb2);
        end
`endif
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_rdy = '0;
        end else begin
            if (prev_rdy != 0) chk("rdy_pulse", {60'b0, req_ready}, 64'd0);
            if (req_ready != 0) chk("rdy_onehot", {63'b0, $onehot(req_ready)}, 64'd1);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    e.id   = 2'(i);
                    e.prod = model(a_arr[i], b_arr[i], req_signed[i]);
                    sb.push_back(e);
                    grant_q.push_back(i);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    timeout("sb_unexpected_rsp");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_id", {62'b0, rsp_id}, {62'b0, e.id});
                    chk("sb_prod", rsp_product, e.prod);
                end
                last_prod = rsp_product;
            end
            prev_rdy = req_ready;
        end
    end

    task automatic set_op(int i, logic [31:0] a, logic [31:0] b, logic s);
        a_arr[i]      = a;
        b_arr[i]      = b;
        req_signed[i] = s;
    endtask

    task automatic wait_ready(int i);
        bit ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin ok = 1; break; end
        end
        if (!ok) timeout("wait_ready");
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) timeout("wait_idle");
    endtask

    task automatic wait_grants(int n);
        bit ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (grant_q.size() >= n) begin ok = 1; break; end
        end
        if (!ok) timeout("wait_grants");
    endtask

    task automatic do_op(int i, logic [31:0] a, logic [31:0] b, logic s,
                         bit dchk, logic [63:0] exp, string tag);
        set_op(i, a, b, s);
        req_valid[i] = 1'b1;
        wait_ready(i);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        wait_idle();
        if (dchk) chk(tag, last_prod, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_signed = '0;
        rsp_ready  = 1'b1;
        for (int i = 0; i < NR; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
        @(posedge clk); #1;
        chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst_rsp_id", {62'b0, rsp_id}, 64'd0);
        chk("rst_rsp_prod", rsp_product, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_req_ready", {60'b0, req_ready}, 64'd0);
        rst = 1'b0;

        // Basic op and latency.
        set_op(0, 32'd12345, 32'd67890, 1'b1);
        req_valid[0] = 1'b1;
        wait_ready(0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk("lat_busy", {63'b0, busy}, 64'd1);
        for (int k = 1; k < LAT; k++) begin
            chk("lat_early", {63'b0, rsp_valid}, 64'd0);
            @(posedge clk); #1;
        end
        chk("lat_early", {63'b0, rsp_valid}, 64'd0);
        @(posedge clk); #1;
        chk("lat_valid", {63'b0, rsp_valid}, 64'd1);
        chk("t1_prod", rsp_product, 64'd838102050);
        chk("t1_id", {62'b0, rsp_id}, 64'd0);
        wait_idle();

        // Signed operands.
`ifdef DADDA_SCHED_SIGNED_EN
        do_op(1, -32'sd9876, 32'd12345, 1'b1, 1, -64'd121919220, "t2_neg");
        do_op(1, -32'sd12345, -32'sd67890, 1'b1, 1, 64'd838102050, "t2_pos");
`else
        do_op(1, -32'sd9876, 32'd12345, 1'b1, 0, 64'd0, "t2_neg");
        do_op(1, -32'sd12345, -32'sd67890, 1'b1, 0, 64'd0, "t2_pos");
`endif

        // Round-robin order with all requesters valid.
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, 32'(i + 3), 32'(7 * i + 11), 1'b0);
        grant_q.delete();
        req_valid = '1;
        wait_grants(5);
        req_valid = '0;
        wait_idle();
        for (int k = 0; k < 5; k++) begin
            chk("rr_order", 64'(grant_q[k]), 64'(k % NR));
        end

        // Back-pressure in HOLD.
        rsp_ready = 1'b0;
        set_op(2, 32'd1000001, 32'd3333, 1'b0);
        req_valid[2] = 1'b1;
        wait_ready(2);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        set_op(3, 32'd77, 32'd99, 1'b0);
        req_valid[3] = 1'b1;
        begin
            bit ok = 0;
            for (int k = 0; k < 20; k++) begin
                if (rsp_valid) begin ok = 1; break; end
                @(posedge clk); #1;
            end
            if (!ok) timeout("hold_wait");
        end
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", {63'b0, rsp_valid}, 64'd1);
            chk("hold_id", {62'b0, rsp_id}, 64'd2);
            chk("hold_prod", rsp_product, 64'd3333003333);
            chk("hold_rdy", {60'b0, req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rel_busy", {63'b0, busy}, 64'd0);
        chk("rel_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rel_rdy", {60'b0, req_ready}, 64'd8);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        wait_idle();

        // Boundary operands.
        do_op(0, 32'd0, -32'sd5, 1'b1, 1, 64'd0, "t5_zero");
`ifdef DADDA_SCHED_SIGNED_EN
        do_op(1, 32'hFFFFFFFF, 32'd2, 1'b1, 1, 64'hFFFFFFFFFFFFFFFE, "t5_m1");
`else
        do_op(1, 32'hFFFFFFFF, 32'd2, 1'b1, 1, 64'h00000001FFFFFFFE, "t5_m1");
`endif
        do_op(2, 32'h80000000, 32'h80000000, 1'b1, 1, 64'h4000000000000000, "t5_min");

        // Reset during MUL.
        set_op(1, 32'd5, 32'd6, 1'b0);
        req_valid[1] = 1'b1;
        wait_ready(1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst_mid_id", {62'b0, rsp_id}, 64'd0);
        chk("rst_mid_prod", rsp_product, 64'd0);
        chk("rst_mid_busy", {63'b0, busy}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("no_stale", {63'b0, rsp_valid}, 64'd0);
        end
        set_op(0, 32'd21, 32'd2, 1'b0);
        set_op(1, 32'd13, 32'd3, 1'b0);
        grant_q.delete();
        req_valid[1:0] = 2'b11;
        #1;
        chk("post_rst_grant", {60'b0, req_ready}, 64'd1);
        wait_grants(1);
        req_valid[0] = 1'b0;
        wait_grants(2);
        req_valid[1] = 1'b0;
        wait_idle();
        chk("post_rst_order", 64'(grant_q[1]), 64'd1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
